// File: rtl/shift_pipe.sv
// rtl/shift_pipe.sv - pipelined LSL/LSR/ASR/ROR shifter with carry-out and valid/ready stages
module shift_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         x,
    input  logic [$clog2(WIDTH)-1:0] sc,
    input  logic [1:0]               md,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         y,
    output logic                     co
);

    localparam int L = $clog2(WIDTH);

    localparam logic [1:0] MD_LSL = 2'b00;
    localparam logic [1:0] MD_LSR = 2'b01;
    localparam logic [1:0] MD_ASR = 2'b10;

    function automatic logic [WIDTH-1:0] shift_level(
        input logic [WIDTH-1:0] d,
        input int               amt,
        input logic [1:0]       m,
        input logic             sgn
    );
        logic [WIDTH-1:0] r;
        case (m)
            MD_LSL:  r = d << amt;
            MD_LSR:  r = d >> amt;
            MD_ASR:  r = (d >> amt) | (sgn ? ~({WIDTH{1'b1}} >> amt) : '0);
            default: r = (d >> amt) | (d << (WIDTH - amt));
        endcase
        return r;
    endfunction

    // Padding by one bit makes n = 0 select the pad, giving co = 0 without a special case.
    logic [WIDTH:0] co_rgt;
    logic [WIDTH:0] co_lft;
    logic           co_in;

    assign co_rgt = {x, 1'b0} >> sc;
    assign co_lft = {1'b0, x} << sc;
    assign co_in  = (md == MD_LSL) ? co_lft[WIDTH] : co_rgt[0];

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int LO = s * L / STAGES;
        localparam int HI = (s + 1) * L / STAGES;

        logic [WIDTH-1:0] src_d;
        logic [WIDTH-1:0] nxt_d;
        logic [WIDTH-1:0] d_q;
        logic [L-1:0]     src_sc;
        logic [L-1:0]     sc_q;
        logic [L-1:0]     sel;
        logic [1:0]       src_md;
        logic [1:0]       md_q;
        logic             src_sgn;
        logic             sgn_q;
        logic             src_co;
        logic             co_q;
        logic             src_v;
        logic             v_q;
        logic             adv;

        if (s == 0) begin : g_src
            assign src_d   = x;
            assign src_sc  = sc;
            assign src_md  = md;
            assign src_sgn = x[WIDTH-1];
            assign src_co  = co_in;
            assign src_v   = in_valid;
        end else begin : g_src
            assign src_d   = g_stage[s-1].d_q;
            assign src_sc  = g_stage[s-1].sc_q;
            assign src_md  = g_stage[s-1].md_q;
            assign src_sgn = g_stage[s-1].sgn_q;
            assign src_co  = g_stage[s-1].co_q;
            assign src_v   = g_stage[s-1].v_q;
        end

        // Empty stages always advance so bubbles collapse toward the output.
        if (s == STAGES - 1) begin : g_adv
            assign adv = !v_q || out_ready;
        end else begin : g_adv
            assign adv = !v_q || g_stage[s+1].adv;
        end

        always_comb begin
            nxt_d = src_d;
            sel   = '0;
            for (int l = LO; l < HI; l++) begin
                sel = src_sc >> l;
                if (sel[0]) begin
                    nxt_d = shift_level(nxt_d, 1 << l, src_md, src_sgn);
                end
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                v_q   <= 1'b0;
                d_q   <= '0;
                sc_q  <= '0;
                md_q  <= '0;
                sgn_q <= 1'b0;
                co_q  <= 1'b0;
            end else if (adv) begin
                v_q <= src_v;
                if (src_v) begin
                    d_q   <= nxt_d;
                    sc_q  <= src_sc;
                    md_q  <= src_md;
                    sgn_q <= src_sgn;
                    co_q  <= src_co;
                end
            end
        end
    end

    assign in_ready  = g_stage[0].adv;
    assign out_valid = g_stage[STAGES-1].v_q;
    assign y         = g_stage[STAGES-1].d_q;
    assign co        = g_stage[STAGES-1].co_q;

    logic unused_tail;
    assign unused_tail = ^{g_stage[STAGES-1].sc_q, g_stage[STAGES-1].md_q,
                           g_stage[STAGES-1].sgn_q, co_lft[WIDTH-1:0], co_rgt[WIDTH:1]};

endmodule

// File: tb/tb_shift_pipe.sv
// tb/tb_shift_pipe.sv - directed-vector bench for shift_pipe (32/2, 8/3, 64/1)
module tb_shift_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        in_valid, in_ready, out_valid, out_ready, co;
    logic [31:0] x, y;
    logic [4:0]  sc;
    logic [1:0]  md;

    logic       v8_in, r8_in, v8_out, r8_out, co8;
    logic [7:0] x8, y8;
    logic [2:0] sc8;
    logic [1:0] md8;

    logic        v64_in, r64_in, v64_out, r64_out, co64;
    logic [63:0] x64, y64;
    logic [5:0]  sc64;
    logic [1:0]  md64;

    shift_pipe #(.WIDTH(32), .STAGES(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .x(x), .sc(sc), .md(md),
        .out_valid(out_valid), .out_ready(out_ready), .y(y), .co(co)
    );

    shift_pipe #(.WIDTH(8), .STAGES(3)) dut8 (
        .clk(clk), .rst(rst), .in_valid(v8_in), .in_ready(r8_in), .x(x8), .sc(sc8), .md(md8),
        .out_valid(v8_out), .out_ready(r8_out), .y(y8), .co(co8)
    );

    shift_pipe #(.WIDTH(64), .STAGES(1)) dut64 (
        .clk(clk), .rst(rst), .in_valid(v64_in), .in_ready(r64_in), .x(x64), .sc(sc64), .md(md64),
        .out_valid(v64_out), .out_ready(r64_out), .y(y64), .co(co64)
    );

    typedef struct {
        logic [1:0]  m;
        logic [4:0]  s;
        logic [31:0] a;
        logic [31:0] r;
        logic        c;
    } vec_t;

    localparam int NV = 17;
    vec_t tbl[NV];

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Runs cnt table vectors starting at first; out_ready is held low for the first
    // stall cycles, then is either always high (rnd = 0) or random.
    task automatic stream(input int first, input int cnt, input int stall, input bit rnd,
                          input int exp_cycles);
        int sent = 0, got = 0, cyc = 0, fl = 0, maxfl = 0;
        bit in_fire, out_fire;
        vec_t v;
        while (got < cnt && cyc < 8000) begin
            in_valid = (sent < cnt) && (!rnd || ($urandom_range(0, 1) == 1));
            v = tbl[(first + sent) % NV];
            md = v.m; sc = v.s; x = v.a;
            out_ready = (cyc >= stall) && (!rnd || ($urandom_range(0, 1) == 1));
            #3;
            if (stall > 0 && cyc >= stall - 2 && cyc < stall) begin
                check("bp_y_hold", y, tbl[first % NV].r);
                if (cyc == stall - 1) begin
                    check("bp_accepted", sent, 2);
                    check("bp_in_ready", in_ready, 0);
                end
            end
            in_fire  = in_valid && in_ready;
            out_fire = out_valid && out_ready;
            if (out_fire) begin
                v = tbl[(first + got) % NV];
                check("y", y, v.r);
                check("co", co, v.c);
                got++;
            end
            if (in_fire) sent++;
            fl = fl + int'(in_fire) - int'(out_fire);
            if (fl > maxfl) maxfl = fl;
            @(posedge clk); #1;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("result_count", got, cnt);
        check("occupancy_le_2", maxfl > 2, 0);
        if (exp_cycles > 0) check("stream_cycles", cyc, exp_cycles);
    endtask

    int  lat;
    bit  seen;

    initial begin
        tbl[0]  = '{2'b10, 5'd4,  32'h80000000, 32'hF8000000, 1'b0};
        tbl[1]  = '{2'b11, 5'd1,  32'h00000001, 32'h80000000, 1'b1};
        tbl[2]  = '{2'b00, 5'd1,  32'h80000001, 32'h00000002, 1'b1};
        tbl[3]  = '{2'b01, 5'd31, 32'hF0000000, 32'h00000001, 1'b1};
        tbl[4]  = '{2'b10, 5'd31, 32'h7FFFFFFF, 32'h00000000, 1'b1};
        tbl[5]  = '{2'b00, 5'd0,  32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0};
        tbl[6]  = '{2'b01, 5'd0,  32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0};
        tbl[7]  = '{2'b10, 5'd0,  32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0};
        tbl[8]  = '{2'b11, 5'd0,  32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0};
        tbl[9]  = '{2'b00, 5'd4,  32'h12345678, 32'h23456780, 1'b1};
        tbl[10] = '{2'b01, 5'd8,  32'h12345678, 32'h00123456, 1'b0};
        tbl[11] = '{2'b10, 5'd8,  32'h87654321, 32'hFF876543, 1'b0};
        tbl[12] = '{2'b11, 5'd16, 32'h87654321, 32'h43218765, 1'b0};
        tbl[13] = '{2'b11, 5'd3,  32'h0000000F, 32'hE0000001, 1'b1};
        tbl[14] = '{2'b10, 5'd31, 32'h80000000, 32'hFFFFFFFF, 1'b0};
        tbl[15] = '{2'b00, 5'd31, 32'hFFFFFFFF, 32'h80000000, 1'b1};
        tbl[16] = '{2'b10, 5'd3,  32'hF0000008, 32'hFE000001, 1'b0};

        rst = 1'b0;
        in_valid = 1'b0; out_ready = 1'b1; x = '0; sc = '0; md = '0;
        v8_in = 1'b0; r8_out = 1'b1; x8 = '0; sc8 = '0; md8 = '0;
        v64_in = 1'b0; r64_out = 1'b1; x64 = '0; sc64 = '0; md64 = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_y", y, 0);
        check("rst_co", co, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid_w8", v8_out, 0);
        check("rst_out_valid_w64", v64_out, 0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Single ASR after reset: latency of two edges.
        in_valid = 1'b1; md = 2'b10; sc = 5'd4; x = 32'h80000000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin @(posedge clk); #1; lat++; end
        check("w32_latency", lat, 2);
        check("w32_asr_y", y, 32'hF8000000);
        check("w32_asr_co", co, 0);
        @(posedge clk); #1;

        stream(0, NV, 0, 1'b0, NV + 2);
        stream(0, 4, 5, 1'b0, 0);
        stream(5, 400, 0, 1'b1, 0);

        // Reset with two operations in flight.
        out_ready = 1'b0;
        in_valid = 1'b1; md = tbl[1].m; sc = tbl[1].s; x = tbl[1].a;
        @(posedge clk); #1;
        md = tbl[2].m; sc = tbl[2].s; x = tbl[2].a;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("full_in_ready", in_ready, 0);
        rst = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_y", y, 0);
        check("midrst_in_ready", in_ready, 1);
        @(posedge clk); #1;
        rst = 1'b1; out_ready = 1'b1;
        seen = 1'b0;
        repeat (5) begin @(posedge clk); #1; seen = seen | out_valid; end
        check("midrst_no_result", seen, 0);

        // WIDTH = 8, three stages.
        v8_in = 1'b1; md8 = 2'b11; sc8 = 3'd7; x8 = 8'h81;
        @(posedge clk); #1;
        v8_in = 1'b0;
        lat = 1;
        while (!v8_out && lat < 10) begin @(posedge clk); #1; lat++; end
        check("w8_latency", lat, 3);
        check("w8_ror_y", y8, 8'h03);
        check("w8_ror_co", co8, 0);

        // WIDTH = 64, one stage.
        v64_in = 1'b1; md64 = 2'b01; sc64 = 6'd63; x64 = 64'hC000000000000000;
        @(posedge clk); #1;
        v64_in = 1'b0;
        lat = 1;
        while (!v64_out && lat < 10) begin @(posedge clk); #1; lat++; end
        check("w64_latency", lat, 1);
        check("w64_lsr_y", y64, 64'h1);
        check("w64_lsr_co", co64, 1);
        v64_in = 1'b1; md64 = 2'b10; sc64 = 6'd63; x64 = 64'h8000000000000000;
        @(posedge clk); #1;
        v64_in = 1'b0;
        check("w64_asr_y", y64, 64'hFFFFFFFFFFFFFFFF);
        check("w64_asr_co", co64, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
